// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused every RUN cycle. The borrow between
// bit positions lives in a register.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    // The counter reaches WIDTH on the final edge, so it needs clog2(WIDTH+1) bits.
    localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_bnext;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs, and the result after inserting the new bit at the MSB.
    always_comb begin
        w_a        = r_a_sh[0];
        w_b        = r_b_sh[0];
        w_d        = w_a ^ w_b ^ r_borrow;
        w_bnext    = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
        w_res_next = r_res_sh >> 1;
        w_res_next[WIDTH-1] = w_d;
        w_last     = (r_cnt == CW'(WIDTH - 1));
    end

    // Next-state logic; start is only looked at in IDLE, DONE always returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, bit-serial shifting and result load on the last RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= A;
                        r_b_sh   <= B;
                        r_borrow <= Bin;
                        r_res_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_borrow <= w_bnext;
                    r_res_sh <= w_res_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_bnext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: one WIDTH=8 and one WIDTH=1 instance.
// Stimulus pushes expected (Diff,Bout) when an operation is issued; monitors pop on done.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       bin8 = 1'b0;
    logic [7:0] diff8;
    logic       bout8;
    logic       busy8;
    logic       done8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       bin1 = 1'b0;
    logic [0:0] diff1;
    logic       bout1;
    logic       busy1;
    logic       done1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done8_cnt = 0;
    int done1_cnt = 0;
    int exp8_cnt  = 0;
    int exp1_cnt  = 0;
    logic prev_done8 = 1'b0;
    logic prev_done1 = 1'b0;

    exp_t q8[$];
    exp_t q1[$];

    // Hand-computed WIDTH=1 truth table, bit index = {A,B,Bin}.
    logic [7:0] exp_d1 = 8'b10010110;
    logic [7:0] exp_b1 = 8'b10001110;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .Diff(diff8), .Bout(bout8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Bin(bin1),
        .Diff(diff1), .Bout(bout1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                exp_t e;
                done8_cnt++;
                chk("busy8_with_done", {31'd0, busy8}, 32'd0);
                chk("done8_back_to_back", {31'd0, prev_done8}, 32'd0);
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done8_unexpected: got done with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = q8.pop_front();
                    chk("diff8", {24'd0, diff8}, {24'd0, e.d});
                    chk("bout8", {31'd0, bout8}, {31'd0, e.b});
                end
            end
            prev_done8 <= done8;
        end else begin
            prev_done8 <= 1'b0;
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (done1) begin
                exp_t e;
                done1_cnt++;
                chk("busy1_with_done", {31'd0, busy1}, 32'd0);
                chk("done1_back_to_back", {31'd0, prev_done1}, 32'd0);
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done1_unexpected: got done with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("diff1", {31'd0, diff1}, {31'd0, e.d[0]});
                    chk("bout1", {31'd0, bout1}, {31'd0, e.b});
                end
            end
            prev_done1 <= done1;
        end else begin
            prev_done1 <= 1'b0;
        end
    end

    task automatic wait_idle8();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy8 && !done8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle8_timeout: got busy=%0b done=%0b expected idle", busy8, done8);
        end
    endtask

    task automatic wait_idle1();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy1 && !done1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle1_timeout: got busy=%0b done=%0b expected idle", busy1, done1);
        end
    endtask

    task automatic wait_done8(output int at_cyc);
        bit ok = 1'b0;
        at_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done8) begin
                ok = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done8_timeout: got no done expected one within 40 cycles");
        end
    endtask

    // One 8-bit operation; optionally checks busy/done/Diff cycle by cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb,
                       input bit timing, input logic [7:0] old_diff);
        int t;
        wait_idle8();
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        q8.push_back('{d: ed, b: eb});
        exp8_cnt++;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; bin8 = ~bin;
        if (timing) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("run8_busy", {31'd0, busy8}, 32'd1);
                chk("run8_done", {31'd0, done8}, 32'd0);
                chk("run8_diff_hold", {24'd0, diff8}, {24'd0, old_diff});
            end
            @(negedge clk);
            chk("lat8_done", {31'd0, done8}, 32'd1);
            chk("lat8_busy", {31'd0, busy8}, 32'd0);
        end else begin
            wait_done8(t);
        end
    endtask

    // One 1-bit operation indexed by {A,B,Bin}; done must follow one cycle after acceptance.
    task automatic op1(input int idx);
        logic [2:0] v;
        v = idx[2:0];
        wait_idle1();
        a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
        q1.push_back('{d: {7'd0, exp_d1[idx]}, b: exp_b1[idx]});
        exp1_cnt++;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1 = ~a1; b1 = ~b1; bin1 = ~bin1;
        @(negedge clk);
        chk("run1_busy", {31'd0, busy1}, 32'd1);
        chk("run1_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        chk("lat1_done", {31'd0, done1}, 32'd1);
        chk("lat1_busy", {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        int t1, t2, t3;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_diff8", {24'd0, diff8}, 32'd0);
        chk("rst_bout8", {31'd0, bout8}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_diff1", {31'd0, diff1}, 32'd0);
        chk("rst_bout1", {31'd0, bout1}, 32'd0);
        rst = 1'b0;

        // Basic operation with full cycle-level timing check.
        op8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b1, 8'h00);

        // Borrow cases.
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00);
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);
        op8(8'h0A, 8'h03, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00);

        // Re-pulse start with new operands at RUN cycles 2 and 5.
        wait_idle8();
        a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        q8.push_back('{d: 8'h23, b: 1'b0});
        exp8_cnt++;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2 || k == 5) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
            end else begin
                start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3; bin8 = 1'b0;
            end
        end
        start8 = 1'b0;
        wait_done8(t1);
        repeat (12) @(negedge clk);
        chk("repulse_done_count", done8_cnt, exp8_cnt);

        // Start held high: one acceptance every WIDTH+2 cycles.
        wait_idle8();
        for (int k = 0; k < 3; k++) begin
            q8.push_back('{d: 8'h0F, b: 1'b0});
            exp8_cnt++;
        end
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        wait_done8(t1);
        wait_done8(t2);
        wait_done8(t3);
        start8 = 1'b0;
        chk("held_interval_1", t2 - t1, 32'd10);
        chk("held_interval_2", t3 - t2, 32'd10);

        // Reset asserted between edges at RUN cycle 4 takes effect immediately.
        wait_idle8();
        chk("pre_rst_diff8", {24'd0, diff8}, 32'h0F);
        a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_diff8", {24'd0, diff8}, 32'd0);
        chk("async_rst_bout8", {31'd0, bout8}, 32'd0);
        chk("async_rst_busy8", {31'd0, busy8}, 32'd0);
        chk("async_rst_done8", {31'd0, done8}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        op8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b1, 8'h00);

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            op1(i);
        end

        repeat (5) @(negedge clk);
        chk("done8_total", done8_cnt, exp8_cnt);
        chk("done1_total", done1_cnt, exp1_cnt);
        chk("q8_empty", q8.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
